// File: rtl/dm_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the FSM state encoding, the port identifiers and the address range check.
package dm_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // Port identifiers used for grant bookkeeping
    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    // The latency counter only needs to hold values up to 7
    localparam int CNT_W = 3;

    // A byte address is in range when every bit above the word index is zero.
    // The whole address is masked so the two byte-offset bits are simply ignored.
    function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
        logic [31:0] high_mask;
        high_mask = 32'hFFFF_FFFF << (addr_w + 2);
        return (addr & high_mask) == 32'd0;
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational round-robin picker for the two data-memory requesters.
// On a tie the port that did not win the previous grant is chosen.
module dm_arb_pick
    import dm_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic gnt_id
);

    // Choose a winner: single requester wins outright, a tie goes to the other port than last time
    always_comb begin
        valid  = req0 | req1;
        gnt_id = ARB_P0;
        if (req0 && req1) begin
            gnt_id = ~last_gnt;
        end else if (req1) begin
            gnt_id = ARB_P1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Sequencing arbiter sharing one fixed-latency single-port data memory between
// the CPU memory stage (port 0) and a secondary master (port 1).
// One access at a time: grant, issue, wait MEM_LAT cycles, report done.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [3:0]        m0_byteen,
    input  logic [31:0]       m0_wdata,
    output logic              m0_done,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [3:0]        m1_byteen,
    input  logic [31:0]       m1_wdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_byteen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    // Latency load value and decrement step sized to the counter
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_id_q,   gnt_id_d;
    logic              err_q,      err_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [3:0]        byteen_q,   byteen_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       rdata_q,    rdata_d;

    logic              pick_valid;
    logic              pick_id;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [3:0]        sel_byteen;
    logic [31:0]       sel_wdata;

    dm_arb_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .gnt_id   (pick_id)
    );

    // Route the picked port's access fields toward the grant latch
    always_comb begin
        sel_we     = m0_we;
        sel_addr   = m0_addr;
        sel_byteen = m0_byteen;
        sel_wdata  = m0_wdata;
        if (pick_id == ARB_P1) begin
            sel_we     = m1_we;
            sel_addr   = m1_addr;
            sel_byteen = m1_byteen;
            sel_wdata  = m1_wdata;
        end
    end

    // Next-state logic: grant and range check in IDLE, one issue cycle, latency countdown, done
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        gnt_id_d   = gnt_id_q;
        err_d      = err_q;
        we_d       = we_q;
        addr_d     = addr_q;
        byteen_d   = byteen_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_id_d   = pick_id;
                    last_gnt_d = pick_id;
                    we_d       = sel_we;
                    addr_d     = sel_addr[ADDR_W+1:2];
                    byteen_d   = sel_byteen;
                    wdata_d    = sel_wdata;
                    rdata_d    = '0;
                    if (addr_in_range(sel_addr, ADDR_W)) begin
                        err_d   = 1'b0;
                        state_d = ARB_ISSUE;
                    end else begin
                        // Out-of-range accesses never touch the memory
                        err_d   = 1'b1;
                        state_d = ARB_DONE;
                    end
                end
            end

            ARB_ISSUE: begin
                cnt_d   = CNT_LAT;
                state_d = ARB_WAIT;
            end

            ARB_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // Captured for writes too; the requester just ignores it
                    rdata_d = mem_rdata;
                    state_d = ARB_DONE;
                end
            end

            ARB_DONE: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and latch registers; reset abandons any access in flight and favours port 0 next
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            last_gnt_q <= ARB_P1;
            gnt_id_q   <= ARB_P0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            byteen_q   <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            gnt_id_q   <= gnt_id_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            byteen_q   <= byteen_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Output decode: memory strobes only in ISSUE, completion only to the granted port
    always_comb begin
        mem_en     = (state_q == ARB_ISSUE);
        mem_we     = mem_en & we_q;
        mem_addr   = addr_q;
        mem_byteen = byteen_q;
        mem_wdata  = wdata_q;
        busy       = (state_q != ARB_IDLE);
        m0_done    = (state_q == ARB_DONE) && (gnt_id_q == ARB_P0);
        m1_done    = (state_q == ARB_DONE) && (gnt_id_q == ARB_P1);
        m0_err     = m0_done & err_q;
        m1_err     = m1_done & err_q;
        m0_rdata   = (gnt_id_q == ARB_P0) ? rdata_q : '0;
        m1_rdata   = (gnt_id_q == ARB_P1) ? rdata_q : '0;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Sequencing arbiter sharing one single-port, fixed-latency data memory between two requesters: port 0 (CPU memory stage, after byte-lane alignment) and port 1 (secondary master, e.g. debug/DMA loader). Accepts one access at a time, grants round-robin, drives the memory for a registered access, waits the configured read latency, returns registered read data with a one-cycle done pulse. Sits between the byte-enable unit / bridge and the DM array.

## Interface
- ADDR_W, 12, word-address width of the memory (2^ADDR_W words)
- MEM_LAT, 1, memory read latency in cycles, legal 1..7
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mN_req  in  1  (N=0,1) access request, held until mN_done
- mN_we  in  1  write access when 1
- mN_addr  in  32  byte address; bits [1:0] ignored
- mN_byteen  in  4  byte-lane write enables (already aligned)
- mN_wdata  in  32  write data (already lane-positioned)
- mN_done  out  1  one-cycle completion pulse
- mN_err  out  1  valid with mN_done; address out of range
- mN_rdata  out  32  registered read word, valid with mN_done
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address
- mem_byteen  out  4  byte-lane enables to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample req. None → stay. One → grant it. Both → grant the port not granted last (last_gnt). Grant latches winner's we/addr/byteen/wdata and port id; last_gnt updates on every grant.
- Range check at grant: addr[31:ADDR_W+2] != 0 → go directly to DONE with err=1, rdata=0, no mem_en.
- ISSUE: mem_en=1, mem_we=latched we, mem_addr=latched addr[ADDR_W+1:2], byteen/wdata from latch; load counter with MEM_LAT → WAIT.
- WAIT: counter decrements each cycle; at count 1, capture mem_rdata into rdata register (also for writes) → DONE.
- DONE: assert done (and err if set) to granted port only, rdata stable; → IDLE. Requests ignored in DONE.
- mem_en, mem_we are 0 in every state except ISSUE; mem_addr/byteen/wdata hold latched values otherwise.
- Write with byteen=4'b0000 is legal: mem_en=1, mem_we=1, no lane changes; completes normally.
- Non-granted port's done/err stay 0; its req stays pending and wins next IDLE arbitration.
- Requester must deassert req the cycle after done or it is taken as a new access.

## Timing
- Reset values: state IDLE, all outputs 0 (done, err, rdata, mem_*, busy), counter 0, last_gnt=1 (port 0 wins first tie).
- Reset mid-access: immediate return to IDLE; access abandoned, no done; pending reqs re-arbitrated after release.
- Req high in IDLE in cycle k → ISSUE cycle k+1 → WAIT cycles k+2..k+1+MEM_LAT → done in cycle k+2+MEM_LAT. MEM_LAT=1: done 3 cycles after req sampled.
- Error path: req in k → done+err in cycle k+1.
- Back-to-back: next grant earliest in cycle after DONE; throughput one access per MEM_LAT+3 cycles.
- Tie on consecutive accesses alternates strictly 0,1,0,1.

## Structure
- const.v gains: `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_DONE` (2-bit encodings) and `ARB_P0`, `ARB_P1` port ids.
- One natural sub-module: dm_arb_pick, combinational round-robin picker (req0, req1, last_gnt → valid, gnt_id). Counter and FSM stay in dm_arbiter.

## Test plan
- Single read, MEM_LAT=1: m0 read addr 0x0000_0010 with mem word 4 = 0xDEAD_BEEF → mem_en one cycle with mem_addr=4, m0_done in cycle k+3, m0_rdata=0xDEAD_BEEF, m0_err=0.
- Tie alternation: m0 and m1 both held requesting 4 accesses → grants 0,1,0,1 after reset; only the granted port sees done.
- Write, MEM_LAT=3: m1 write addr 0x20, byteen 4'b1100, wdata 0xABCD_0000 → single mem_en with mem_we=1, mem_byteen=4'b1100, mem_addr=8; m1_done in cycle k+5.
- Out of range, ADDR_W=12: m0 read 0x0000_4000 → m0_done+m0_err in k+1, rdata=0, mem_en never asserted.
- Reset mid-WAIT (MEM_LAT=4): assert reset at WAIT cycle 2 → all outputs 0 immediately, no done; after release m1 and m0 both requesting → m0 granted first.
- Byteen 0 write: m0 write byteen 4'b0000 → mem_en=1, mem_we=1, mem_byteen=0, memory contents unchanged, done at k+2+MEM_LAT.
